// File: rtl/banked_sram_ctrl.sv
`default_nettype none
// ============================================================================
// banked_sram_ctrl : multi-bank byte-enabled SRAM, 2-cycle read pipe, clear sweep
// Revision: 1.0
// ============================================================================
module banked_sram_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_BANKS  = 2,
  localparam int BANK_WIDTH = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  ce,
  input  logic                  we,
  input  logic [BE_WIDTH-1:0]   be,
  input  logic [BANK_WIDTH-1:0] bank,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] d,
  output logic                  ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_err
);

  typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;

  logic                  req_vld_q, req_vld_d, req_err_q, req_err_d;
  logic [BANK_WIDTH-1:0] req_bank_q, req_bank_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  s1_vld_q, s1_vld_d, s1_err_q, s1_err_d;
  logic [BANK_WIDTH-1:0] s1_bank_q, s1_bank_d;
  logic                  rd_valid_q, rd_valid_d, rd_err_q, rd_err_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                  run_w, accept_w, bank_ok_w;
  logic [DATA_WIDTH-1:0] bank_rd_w [NUM_BANKS];
  logic [DATA_WIDTH-1:0] sel_w;

  assign run_w     = (state_q == RUN);
  assign accept_w  = run_w & ce & ~clr;
  assign bank_ok_w = (32'(bank) < NUM_BANKS);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    req_vld_d  = accept_w & ~we;
    req_err_d  = req_err_q;
    req_bank_d = req_bank_q;
    req_addr_d = req_addr_q;
    s1_vld_d   = req_vld_q;
    s1_err_d   = s1_err_q;
    s1_bank_d  = s1_bank_q;
    rd_valid_d = s1_vld_q;
    rd_err_d   = rd_err_q;
    rd_data_d  = rd_data_q;

    case (state_q)
      CLEAR: begin
        if (clr) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      end
      default: state_d = CLEAR;
    endcase

    if (accept_w & ~we) begin
      req_err_d  = ~bank_ok_w;
      req_bank_d = bank;
      req_addr_d = addr;
    end
    if (req_vld_q) begin
      s1_err_d  = req_err_q;
      s1_bank_d = req_bank_q;
    end
    // Output register only loads on a completing read so rd_data/rd_err hold otherwise.
    if (s1_vld_q) begin
      rd_err_d  = s1_err_q;
      rd_data_d = s1_err_q ? '0 : sel_w;
    end
  end

  always_comb begin
    sel_w = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (s1_bank_q == BANK_WIDTH'(i)) sel_w = bank_rd_w[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      req_vld_q  <= 1'b0;
      req_err_q  <= 1'b0;
      req_bank_q <= '0;
      req_addr_q <= '0;
      s1_vld_q   <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_bank_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      req_vld_q  <= req_vld_d;
      req_err_q  <= req_err_d;
      req_bank_q <= req_bank_d;
      req_addr_q <= req_addr_d;
      s1_vld_q   <= s1_vld_d;
      s1_err_q   <= s1_err_d;
      s1_bank_q  <= s1_bank_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_word_q;
    logic                  wr_en_w, rd_en_w;

    assign wr_en_w = accept_w & we & (bank == BANK_WIDTH'(i));
    assign rd_en_w = req_vld_q & (req_bank_q == BANK_WIDTH'(i));

    // Array has no reset; the clear sweep owns initialisation.
    always_ff @(posedge clk) begin
      if (!run_w) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_en_w) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (be[b]) mem_q[addr][8*b +: 8] <= d[8*b +: 8];
        end
      end
      if (rd_en_w) rd_word_q <= mem_q[req_addr_q];
    end

    assign bank_rd_w[i] = rd_word_q;
  end

  assign ready    = ready_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_banked_sram_ctrl.sv
`default_nettype none
// Scoreboard bench for banked_sram_ctrl (3 banks, 256 words, 32-bit).
module tb_banked_sram_ctrl;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NB = 3;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          reset_n, clr, ce, we;
  logic [3:0]    be;
  logic [BW-1:0] bank;
  logic [AW-1:0] addr;
  logic [DW-1:0] d;
  logic          ready, rd_valid, rd_err;
  logic [DW-1:0] rd_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW:0] exp_q [$];

  banked_sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .ce(ce), .we(we), .be(be),
    .bank(bank), .addr(addr), .d(d), .ready(ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int b, input int a, input logic [DW-1:0] data, input logic [3:0] ben);
    ce = 1'b1; we = 1'b1; bank = BW'(b); addr = AW'(a); d = data; be = ben;
    tick();
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic do_read(input int b, input int a, input logic err, input logic [DW-1:0] data);
    ce = 1'b1; we = 1'b0; bank = BW'(b); addr = AW'(a);
    exp_q.push_back({err, data});
    tick();
    ce = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (ready !== 1'b1 && cyc < 1000) begin
      tick();
      cyc++;
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rd_valid: got data %0h err %0b, expected no read", rd_data, rd_err);
      end else begin
        check("read_resp", {31'd0, rd_err, rd_data}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int   cyc;
    logic low_bad;
    reset_n = 1'b0; clr = 1'b0; ce = 1'b0; we = 1'b0;
    be = 4'h0; bank = '0; addr = '0; d = '0;
    repeat (3) tick();
    check("rst_ready", ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_err", rd_err, 0);
    check("rst_rd_data", rd_data, 0);

    // Sweep after reset release; ce pulses mid-sweep must be ignored.
    reset_n = 1'b1;
    low_bad = 1'b0;
    for (int c = 1; c <= 256; c++) begin
      ce = (c == 10 || c == 20); we = (c == 20);
      bank = (c == 20) ? 2'd0 : 2'd1; addr = (c == 20) ? 8'd7 : 8'd0;
      d = 32'hFFFF_FFFF; be = 4'hF;
      tick();
      if (c < 256 && ready !== 1'b0) low_bad = 1'b1;
    end
    ce = 1'b0; we = 1'b0;
    check("ready_low_during_sweep", low_bad, 0);
    check("ready_after_sweep", ready, 1);

    do_write(1, 1, 32'h0000_0001, 4'hF);
    do_read(1, 1, 1'b0, 32'h0000_0001);
    tick();
    check("latency_edge1", rd_valid, 0);
    tick();
    check("latency_edge2", rd_valid, 1);
    do_read(0, 1, 1'b0, 32'h0);
    do_read(0, 7, 1'b0, 32'h0);

    do_write(0, 2, 32'hAABB_CCDD, 4'hF);
    do_write(0, 2, 32'h1122_3344, 4'b0101);
    do_read(0, 2, 1'b0, 32'hAA22_CC44);
    do_write(0, 2, 32'h0, 4'h0);
    do_read(0, 2, 1'b0, 32'hAA22_CC44);

    for (int a = 0; a < 4; a++) do_write(2, a, 32'h10 + a, 4'hF);
    for (int a = 0; a < 4; a++) do_read(2, a, 1'b0, 32'h10 + a);
    repeat (4) tick();
    check("hold_rd_data", rd_data, 32'h13);
    check("hold_rd_valid", rd_valid, 0);

    do_read(1, 1, 1'b0, 32'h0000_0001);
    do_write(1, 1, 32'h0000_0055, 4'hF);
    do_read(1, 1, 1'b0, 32'h0000_0055);

    do_write(3, 4, 32'hDEAD_BEEF, 4'hF);
    do_read(3, 4, 1'b1, 32'h0);
    for (int b = 0; b < NB; b++) do_read(b, 4, 1'b0, 32'h0);
    repeat (4) tick();
    check("err_holds_after_ok", rd_err, 0);

    // clr one cycle after a read: the read still completes.
    do_read(2, 0, 1'b0, 32'h10);
    clr = 1'b1;
    ce = 1'b1; we = 1'b1; bank = 2'd2; addr = 8'd9; d = 32'h9999_9999; be = 4'hF;
    tick();
    clr = 1'b0; ce = 1'b0; we = 1'b0;
    check("ready_drop_on_clr", ready, 0);
    wait_ready(cyc);
    check("clr_sweep_len", cyc, 256);
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 256; a++) do_read(b, a, 1'b0, 32'h0);
    repeat (4) tick();

    // Reset while a read is in flight discards it.
    do_read(2, 1, 1'b0, 32'h0);
    reset_n = 1'b0;
    exp_q.delete();
    tick();
    check("rst_midread_valid0", rd_valid, 0);
    tick();
    check("rst_midread_valid1", rd_valid, 0);
    reset_n = 1'b1;
    tick();
    check("rst_midread_valid2", rd_valid, 0);
    check("rst_ready_low", ready, 0);
    wait_ready(cyc);
    check("rst_sweep_len", cyc, 255);
    do_read(1, 1, 1'b0, 32'h0);
    repeat (4) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/banked_sram_ctrl.md
# banked_sram_ctrl

Parametrised multi-bank single-port SRAM block with a byte-enabled write path, a two-stage registered read pipeline with a valid strobe, and a hardware clear sequencer. It replaces the single-bank memory-plus-output-register top level: one request port is steered to NUM_BANKS independent banks, and read data is returned with fixed latency and an explicit qualifier instead of a separately enabled output register. It sits between the compute datapath and on-chip storage.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, per-bank word address width; bank depth is 2**ADDR_WIDTH.
- NUM_BANKS, 2, bank count, 1..16.
- BANK_WIDTH (localparam), max(1, clog2(NUM_BANKS)).
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous request to re-run the clear sweep.
- ce  in  1  request strobe; one request per cycle.
- we  in  1  1 = write, 0 = read; sampled with ce.
- be  in  DATA_WIDTH/8  byte enables for writes; ignored on reads.
- bank  in  BANK_WIDTH  target bank.
- addr  in  ADDR_WIDTH  word address within bank.
- d  in  DATA_WIDTH  write data.
- ready  out  1  1 = requests accepted; 0 during clear sweep.
- rd_valid  out  1  one-cycle qualifier for rd_data.
- rd_data  out  DATA_WIDTH  read data; holds last value while rd_valid = 0.
- rd_err  out  1  qualifies rd_valid; 1 = read targeted bank >= NUM_BANKS.

## Operation
- FSM states: CLEAR, RUN.
- reset_n low: state <= CLEAR, sweep counter <= 0, ready = 0, rd_valid = 0, rd_err = 0, rd_data = 0, pipeline valid bits cleared. Array contents are not reset asynchronously.
- CLEAR: each cycle writes 0 to word [counter] of every bank in parallel; counter increments; after writing word 2**ADDR_WIDTH-1, state <= RUN and ready <= 1. Sweep takes exactly 2**ADDR_WIDTH cycles.
- In CLEAR, ce is ignored: no write, no read, no rd_valid.
- RUN, ce=1, we=1, bank < NUM_BANKS: for each i with be[i]=1, byte i of word [bank][addr] <= d byte i; other bytes unchanged. be = 0 is a legal no-op.
- RUN, ce=1, we=1, bank >= NUM_BANKS: write dropped silently.
- RUN, ce=1, we=0: read enters the pipeline (stage 1: array read register; stage 2: output register). Out-of-range bank returns rd_data = 0 with rd_err = 1.
- clr=1 in RUN: state <= CLEAR at the next edge, counter <= 0, ready <= 0; a ce in the same cycle is ignored. Reads already in the pipeline complete normally. clr in CLEAR restarts the counter at 0.
- Reset mid-sweep or mid-read: in-flight reads are discarded; sweep restarts from 0 after reset_n rises.

## Timing
- Read request sampled at edge N -> rd_valid = 1, rd_data valid, after edge N+2 for exactly one cycle. Latency 2, throughput 1 read/cycle; back-to-back reads produce back-to-back rd_valid.
- Write sampled at edge N is visible to a read sampled at edge N+1 (no stale data).
- Interleaved R,W,R to one address: first read returns old data, second returns new data.
- ready rises after the edge that writes the last clear word; first acceptable request is at the following edge.
- rd_data and rd_err change only on edges where stage 2 is loaded; otherwise they hold.

## Test plan
- Reset release with ADDR_WIDTH=8: ready stays 0 for 256 cycles after reset_n rises, then 1; a ce pulse during the sweep produces no rd_valid.
- Write bank 1 addr 0x01 d=0x00000001 be=4'hF, then read it -> rd_valid 2 cycles later with rd_data = 0x00000001, rd_err = 0; bank 0 addr 0x01 reads 0x00000000.
- Write 0xAABBCCDD be=4'hF, then 0x11223344 be=4'b0101 to the same word; read -> 0xAA22CC44.
- Reads of addrs 0,1,2,3 on four consecutive cycles after writing 0x10,0x11,0x12,0x13 -> four consecutive rd_valid cycles returning 0x10..0x13 in order; rd_data holds 0x13 afterwards.
- NUM_BANKS=3: write bank 3 then read bank 3 -> rd_valid with rd_err = 1, rd_data = 0; banks 0..2 unchanged.
- Assert clr one cycle after a read request -> that read still returns its data; ready drops, all words read back 0 after the sweep. Pulse reset_n low mid-read -> rd_valid stays 0 and the sweep restarts.
